mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the single-ported unified memory between two requesters: instruction fetch (IF, read-only) and load/store (LSU, read/write). Arbitrates round-robin, latches the winning request, drives the memory for a fixed latency, then returns a one-cycle response to the winner. Sits between the control sequencer, the fetch path and the data memory. Pauses new grants while halt is high.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, memory access cycles, minimum 1; mem_rdata is valid in the last access cycle

Ports:
Clk  in  1  clock, rising edge
peripheral_reset  in  1  asynchronous, active-high reset
halt  in  1  blocks new grants; an in-flight access still completes
if_req  in  1  IF read request, held until if_gnt
if_addr  in  AW  IF address
if_gnt  out  1  one-cycle pulse, IF request accepted
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DW  IF read data
lsu_req  in  1  LSU request, held until lsu_gnt
lsu_we  in  1  1 = write, 0 = read
lsu_addr  in  AW  LSU address
lsu_wdata  in  DW  LSU write data
lsu_gnt  out  1  one-cycle pulse, LSU request accepted
lsu_rvalid  out  1  one-cycle pulse, read data valid or write done
lsu_rdata  out  DW  LSU read data; 0 on write completion
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, any state): state=IDLE, every output 0, counter=0, last_grant=LSU (so IF wins the first tie).
- All outputs are registered. No combinational path from a req input to any output.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If halt=0 and any req is high at an edge, go to ACCESS.
  - Latch owner, we, addr and wdata. IF always uses we=0.
  - For the next cycle: assert the owner's gnt (1 cycle), mem_en=1, and drive mem_we/mem_addr/mem_wdata from the latched values. counter=0.
  - If halt=1, stay in IDLE and issue no gnt, even with req high.
- Arbitration, both req high: grant the port that is not last_grant. Single req: grant that port. Update last_grant on every grant.
- ACCESS:
  - mem_en and the latched memory signals are held stable for exactly MEM_LAT cycles.
  - counter increments each cycle. When counter == MEM_LAT-1, capture mem_rdata at that edge and go to RESP.
  - Leaving ACCESS drops mem_en and mem_we to 0; mem_addr and mem_wdata hold their values.
  - halt has no effect in ACCESS.
- RESP:
  - One cycle. The owner's rvalid=1 and its rdata = captured data (0 if the access was a write).
  - Always returns to IDLE. rdata holds its value after rvalid drops.
- Latency: req sampled at edge k → gnt high in cycle k+1 → rvalid high in cycle k+MEM_LAT+1 → next request sampled at edge k+MEM_LAT+2.
- Each requester may change addr/wdata or drop req after seeing gnt. A req held high after gnt is treated as a new request.
- Requests dropped before gnt are lost, with no error flag.
- Reset mid-ACCESS abandons the access: mem_en and mem_we go low immediately, and no rvalid is issued.
- At most one gnt and one rvalid are high in any cycle. gnt and rvalid are never high together.
- Counter width is clog2(MEM_LAT)+1. It must not wrap while in ACCESS.

Test Plan:
- Reset then IF read: if_req=1, if_addr=0x10, MEM_LAT=2, mem returns 0xDEADBEEF → if_gnt in cycle 1, mem_en in cycles 1–2 with mem_addr=0x10, if_rvalid in cycle 3 with if_rdata=0xDEADBEEF, busy=0 in cycle 4.
- LSU write: lsu_we=1, addr=0x20, wdata=0x12345678 → mem_we=1 for exactly 2 cycles with those values, lsu_rvalid pulse, lsu_rdata=0, if_* stay 0.
- Both req held continuously from reset → grants alternate IF, LSU, IF, LSU. Each access spans MEM_LAT+2 cycles and never overlaps another.
- halt=1 with if_req=1 for 5 cycles → no gnt, busy=0. Drop halt → if_gnt next cycle. halt raised mid-ACCESS → the access still completes with rvalid.
- peripheral_reset pulsed in the second ACCESS cycle → mem_en=0 immediately and no rvalid. The next request is granted normally, with IF winning the tie.
- Sweep MEM_LAT=1 and MEM_LAT=4 → mem_en high for exactly MEM_LAT cycles, rvalid at k+MEM_LAT+1, rdata equals the mem_rdata value in the last access cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (read-only) and load/store.
// Latency: gnt one cycle after req; rvalid MEM_LAT+1 cycles after req; halt holds off new grants.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          Clk,
    input  logic          peripheral_reset,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          lsu_req,
    input  logic          lsu_we,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    output logic          lsu_gnt,
    output logic          lsu_rvalid,
    output logic [DW-1:0] lsu_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    localparam int CW = $clog2(MEM_LAT) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] counter;
    logic          last_lsu;
    logic          owner_lsu;
    logic          acc_we;
    logic          pick_if;
    logic          pick_lsu;

    // Tie goes to whichever port did not win last time.
    always_comb begin
        pick_if  = if_req && (!lsu_req || last_lsu);
        pick_lsu = lsu_req && !pick_if;
    end

    always_ff @(posedge Clk or posedge peripheral_reset) begin
        if (peripheral_reset) begin
            state      <= S_IDLE;
            counter    <= '0;
            last_lsu   <= 1'b1;
            owner_lsu  <= 1'b0;
            acc_we     <= 1'b0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            lsu_gnt    <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            if_gnt     <= 1'b0;
            lsu_gnt    <= 1'b0;
            if_rvalid  <= 1'b0;
            lsu_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!halt && (if_req || lsu_req)) begin
                        state     <= S_ACCESS;
                        busy      <= 1'b1;
                        counter   <= '0;
                        mem_en    <= 1'b1;
                        owner_lsu <= pick_lsu;
                        last_lsu  <= pick_lsu;
                        if_gnt    <= pick_if;
                        lsu_gnt   <= pick_lsu;
                        if (pick_lsu) begin
                            mem_we    <= lsu_we;
                            acc_we    <= lsu_we;
                            mem_addr  <= lsu_addr;
                            mem_wdata <= lsu_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            acc_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    // mem_rdata is sampled at the end of the last access cycle.
                    if (counter == CW'(MEM_LAT - 1)) begin
                        state  <= S_RESP;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner_lsu) begin
                            lsu_rvalid <= 1'b1;
                            lsu_rdata  <= acc_we ? '0 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
